neural_acq_engine: RTL and testbench

NEURAL_ACQ_ENGINE -- requirements
Module: neural_acq_engine

---
 rtl/neural_acq_engine.sv | 124 ++++++++++++
 tb/tb_neural_acq_engine.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/neural_acq_engine.sv
// Neural ADC acquisition: channel mask + spike threshold gate, timestamped packets into a show-ahead FIFO.
// Latency: admitting sample edge -> stage -> FIFO, so out_valid rises two edges later when the FIFO is empty.
// Backpressure: out_valid/out_ready; a stage write that meets a full FIFO with no pop is dropped and counted.
module neural_acq_engine #(
    parameter int SAMPLE_W   = 12,
    parameter int TS_W       = 16,
    parameter int NUM_CH     = 16,
    parameter int FIFO_DEPTH = 32,
    parameter int DROP_W     = 8,
    localparam int CH_W      = $clog2(NUM_CH),
    localparam int ADDR_W    = $clog2(FIFO_DEPTH),
    localparam int PKT_W     = CH_W + TS_W + SAMPLE_W
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_sample,
    input  logic [CH_W-1:0]     in_channel,
    input  logic                cfg_mode,
    input  logic [NUM_CH-1:0]   cfg_ch_mask,
    input  logic [SAMPLE_W-1:0] cfg_threshold,
    input  logic                cfg_clr_drop,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PKT_W-1:0]    out_data,
    output logic [ADDR_W:0]     fifo_level,
    output logic [DROP_W-1:0]   drop_cnt,
    output logic                overflow
);

    typedef struct packed {
        logic [CH_W-1:0]     ch;
        logic [TS_W-1:0]     ts;
        logic [SAMPLE_W-1:0] smp;
    } pkt_t;

    localparam logic [SAMPLE_W:0] MID = {2'b01, {(SAMPLE_W-1){1'b0}}};

    logic [TS_W-1:0]   ts_q, ts_d;
    logic              stg_vld_q;
    pkt_t              stg_q;
    pkt_t              mem_q [FIFO_DEPTH];
    logic [ADDR_W:0]   wptr_q, rptr_q;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              overflow_q, overflow_d;

    logic              mask_bit;
    logic [SAMPLE_W:0] smp_ext, dev;
    logic              admit;
    logic              empty, full, pop, push, drop;

    // Out-of-range channel indices (non-power-of-two NUM_CH) match no mask bit.
    always_comb begin
        mask_bit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_channel == CH_W'(i)) mask_bit = cfg_ch_mask[i];
        end
    end

    assign smp_ext = {1'b0, in_sample};
    assign dev     = (smp_ext >= MID) ? (smp_ext - MID) : (MID - smp_ext);
    assign admit   = in_valid && mask_bit && (!cfg_mode || (dev >= {1'b0, cfg_threshold}));

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                   (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
    assign pop   = !empty && out_ready;
    // A full FIFO still takes the stage entry when the head leaves on the same edge.
    assign push  = stg_vld_q && (!full || pop);
    assign drop  = stg_vld_q && full && !pop;

    always_comb begin
        ts_d = ts_q;
        if (in_valid) ts_d = ts_q + TS_W'(1);
    end

    // Clear wins over history, but a drop on the clearing edge is still recorded.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (cfg_clr_drop) begin
            drop_cnt_d = drop ? DROP_W'(1) : '0;
            overflow_d = drop;
        end else if (drop) begin
            if (drop_cnt_q != {DROP_W{1'b1}}) drop_cnt_d = drop_cnt_q + DROP_W'(1);
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ts_q       <= '0;
            stg_vld_q  <= 1'b0;
            stg_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            stg_vld_q  <= admit;
            if (admit) begin
                stg_q.ch  <= in_channel;
                stg_q.ts  <= ts_q;
                stg_q.smp <= in_sample;
            end
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wptr_q[ADDR_W-1:0]] <= stg_q;
    end

    assign out_valid  = !empty;
    assign out_data   = empty ? '0 : mem_q[rptr_q[ADDR_W-1:0]];
    assign fifo_level = wptr_q - rptr_q;
    assign drop_cnt   = drop_cnt_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_neural_acq_engine.sv
// Scoreboard bench for neural_acq_engine built with 10 channels so an out-of-range index is representable.
module tb_neural_acq_engine;

    localparam int SAMPLE_W = 12;
    localparam int TS_W     = 16;
    localparam int NUM_CH   = 10;
    localparam int DEPTH    = 32;
    localparam int DROP_W   = 8;
    localparam int CH_W     = 4;
    localparam int PKT_W    = CH_W + TS_W + SAMPLE_W;

    logic                sys_clk = 1'b0;
    logic                sys_rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic [SAMPLE_W-1:0] in_sample = '0;
    logic [CH_W-1:0]     in_channel = '0;
    logic                cfg_mode = 1'b0;
    logic [NUM_CH-1:0]   cfg_ch_mask = '1;
    logic [SAMPLE_W-1:0] cfg_threshold = '0;
    logic                cfg_clr_drop = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [PKT_W-1:0]    out_data;
    logic [5:0]          fifo_level;
    logic [DROP_W-1:0]   drop_cnt;
    logic                overflow;

    int n_cmp = 0;
    int n_err = 0;
    logic [PKT_W-1:0] sb [$];

    neural_acq_engine #(
        .SAMPLE_W(SAMPLE_W), .TS_W(TS_W), .NUM_CH(NUM_CH),
        .FIFO_DEPTH(DEPTH), .DROP_W(DROP_W)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .in_valid(in_valid), .in_sample(in_sample), .in_channel(in_channel),
        .cfg_mode(cfg_mode), .cfg_ch_mask(cfg_ch_mask), .cfg_threshold(cfg_threshold),
        .cfg_clr_drop(cfg_clr_drop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fifo_level(fifo_level), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    always #5 sys_clk = ~sys_clk;

    // Monitor: every accepted packet must match the oldest expectation.
    always @(negedge sys_clk) begin
        if (sys_rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pkt: got %0h, none expected", out_data);
            end else begin
                logic [PKT_W-1:0] e;
                e = sb.pop_front();
                if (out_data !== e) begin
                    n_err++;
                    $display("FAIL pkt_data: got %0h expected %0h", out_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [CH_W-1:0] ch, input logic [SAMPLE_W-1:0] s,
                        input bit exp, input logic [TS_W-1:0] ts);
        in_valid   = 1'b1;
        in_channel = ch;
        in_sample  = s;
        if (exp) sb.push_back({ch, ts, s});
        @(posedge sys_clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 sys_rst_n = 1'b0;
        sb.delete();
        in_valid = 1'b0;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;

        // Raw streaming, latency of the first packet
        cfg_mode = 1'b0; cfg_ch_mask = '1; out_ready = 1'b1;
        send(4'd2, 12'h123, 1, 16'd0);
        chk("lat_edge1_valid", 32'(out_valid), 32'd0);
        send(4'd5, 12'h456, 1, 16'd1);
        chk("lat_edge2_valid", 32'(out_valid), 32'd1);
        send(4'd7, 12'h789, 1, 16'd2);
        repeat (4) @(posedge sys_clk);
        #1 chk("raw_drained", 32'(sb.size()), 32'd0);

        // Spike-threshold mode: deviations 0, 300, 301, 252 against 300
        do_reset();
        cfg_mode = 1'b1; cfg_threshold = 12'd300;
        send(4'd1, 12'd2048, 0, 16'd0);
        send(4'd1, 12'd2348, 1, 16'd1);
        send(4'd1, 12'd1747, 1, 16'd2);
        send(4'd1, 12'd2300, 0, 16'd3);
        repeat (4) @(posedge sys_clk);
        #1 chk("thr_drained", 32'(sb.size()), 32'd0);
        chk("thr_level", 32'(fifo_level), 32'd0);

        // Masked channel and out-of-range channel still advance the timestamp
        do_reset();
        cfg_mode = 1'b0; cfg_ch_mask = 10'h3F7;
        send(4'd3, 12'h033, 0, 16'd0);
        send(4'd10, 12'h0AA, 0, 16'd1);
        send(4'd4, 12'h005, 1, 16'd2);
        repeat (4) @(posedge sys_clk);
        #1 chk("mask_drained", 32'(sb.size()), 32'd0);
        cfg_ch_mask = '1;

        // Overflow: 34 samples into a 32-entry FIFO with the consumer stalled
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 34; i++) send(4'd0, 12'(i + 16), (i < 32), 16'(i));
        repeat (2) @(posedge sys_clk);
        #1 chk("ovf_level", 32'(fifo_level), 32'd32);
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_head_stable", out_data, {4'd0, 16'd0, 12'd16});

        // Full FIFO, pop and stage write on the same edge
        send(4'd1, 12'h777, 1, 16'd34);
        out_ready = 1'b1;
        @(posedge sys_clk);
        #1 chk("full_pushpop_level", 32'(fifo_level), 32'd32);
        chk("full_pushpop_drop", 32'(drop_cnt), 32'd2);
        repeat (40) @(posedge sys_clk);
        #1 chk("ovf_drained", 32'(sb.size()), 32'd0);
        chk("ovf_level_empty", 32'(fifo_level), 32'd0);

        cfg_clr_drop = 1'b1;
        @(posedge sys_clk);
        #1 cfg_clr_drop = 1'b0;
        chk("clr_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("clr_overflow", 32'(overflow), 32'd0);

        // Asynchronous reset with 10 entries buffered
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) send(4'd2, 12'(i + 100), 1, 16'(i));
        repeat (2) @(posedge sys_clk);
        #1 chk("pre_rst_level", 32'(fifo_level), 32'd10);
        #3 sys_rst_n = 1'b0;
        sb.delete();
        #1 chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_level", 32'(fifo_level), 32'd0);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        out_ready = 1'b1;
        send(4'd6, 12'hABC, 1, 16'd0);
        repeat (4) @(posedge sys_clk);
        #1 chk("post_rst_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
